mmio_io_unit: RTL and testbench

//  Memory-mapped I/O peripheral on the CPU memory bus, in parallel with the RAM.

---
 rtl/io_pkg.sv | 21 ++
 rtl/mmio_io_unit_if.sv | 12 +
 rtl/sw_debounce.sv | 44 ++++
 rtl/mmio_io_unit.sv | 81 ++++++++
 tb/tb_mmio_io_unit.sv | 188 ++++++++++++++++++
 5 files changed

// File: rtl/io_pkg.sv
// Shared bus command encodings and register addresses for the memory-mapped I/O unit.
package io_pkg;

   typedef enum logic [1:0] {
      MIDLE  = 2'd0,
      MREAD  = 2'd1,
      MNONE  = 2'd2,
      MWRITE = 2'd3
   } mem_cmd_t;

   localparam logic [7:0] IO_LED   = 8'h00;
   localparam logic [7:0] IO_SW    = 8'h40;
   localparam logic [7:0] IO_SWCHG = 8'h41;
   localparam logic [7:0] IO_CYC   = 8'h42;

   // Address bit 8 splits the bus between RAM (0) and this unit (1).
   function automatic logic io_hit(input logic [8:0] addr);
      return addr[8];
   endfunction

endpackage

// File: rtl/mmio_io_unit_if.sv
// CPU memory-bus command side as seen by the I/O unit.
interface mmio_io_unit_if;
   // No handshake: a command is accepted in the cycle it is presented; read_en is high
   // exactly in the cycles where the unit drives the shared read_data bus.
   logic [1:0]  mem_cmd;
   logic [8:0]  mem_addr;
   logic [15:0] write_data;
   logic        read_en;

   modport master (output mem_cmd, mem_addr, write_data, input read_en);
   modport slave  (input mem_cmd, mem_addr, write_data, output read_en);
endinterface

// File: rtl/sw_debounce.sv
// Two-flop synchronizer plus hold-time debounce for the eight slide switches.
module sw_debounce #(
   parameter int unsigned DB_CYCLES = 1000,
   parameter int          DB_W      = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] sw_in,
   output logic [7:0] sw_db,
   output logic       changed
);

   localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);

   logic [7:0]      sw_m;
   logic [7:0]      sw_s;
   logic [DB_W-1:0] db_cnt;

   // Combinational so the flag in the top sets on the same edge sw_db updates.
   assign changed = (sw_s != sw_db) && (db_cnt == DB_LAST);

   always_ff @(posedge clk) begin
      if (reset) begin
         sw_m   <= '0;
         sw_s   <= '0;
         sw_db  <= '0;
         db_cnt <= '0;
      end else begin
         sw_m <= sw_in;
         sw_s <= sw_m;
         if (sw_s != sw_db) begin
            if (db_cnt == DB_LAST) begin
               sw_db  <= sw_s;
               db_cnt <= '0;
            end else begin
               db_cnt <= db_cnt + DB_W'(1);
            end
         end else begin
            db_cnt <= '0;
         end
      end
   end

endmodule

// File: rtl/mmio_io_unit.sv
// Memory-mapped LED/switch/cycle-counter peripheral sharing the tri-stated read bus with RAM.
module mmio_io_unit
   import io_pkg::*;
#(
   parameter int unsigned DB_CYCLES = 1000,
   parameter int          DB_W      = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   mmio_io_unit_if.slave        bus,
   output wire  [15:0]          read_data,
   input  logic [7:0]           sw_in,
   output logic [7:0]           ledr
);

   logic        sel;
   logic        rd;
   logic        wr;
   logic [7:0]  reg_addr;
   logic [7:0]  led_reg;
   logic [7:0]  sw_db;
   logic        changed;
   logic        chg_flag;
   logic [15:0] cyc_cnt;
   logic [15:0] rdata;

   assign sel      = ((bus.mem_cmd == MREAD) || (bus.mem_cmd == MWRITE)) && io_hit(bus.mem_addr);
   assign rd       = sel && (bus.mem_cmd == MREAD);
   assign wr       = sel && (bus.mem_cmd == MWRITE);
   assign reg_addr = bus.mem_addr[7:0];

   sw_debounce #(
      .DB_CYCLES (DB_CYCLES),
      .DB_W      (DB_W)
   ) u_debounce (
      .clk     (clk),
      .reset   (reset),
      .sw_in   (sw_in),
      .sw_db   (sw_db),
      .changed (changed)
   );

   always_comb begin
      rdata = 16'h0000;
      case (reg_addr)
         IO_LED:   rdata = {8'h00, led_reg};
         IO_SW:    rdata = {8'h00, sw_db};
         IO_SWCHG: rdata = {15'h0000, chg_flag};
         IO_CYC:   rdata = cyc_cnt;
         default:  rdata = 16'h0000;
      endcase
   end

   assign read_data   = rd ? rdata : 16'bz;
   assign bus.read_en = rd;
   assign ledr        = led_reg;

   always_ff @(posedge clk) begin
      if (reset) begin
         led_reg  <= '0;
         chg_flag <= 1'b0;
         cyc_cnt  <= '0;
      end else begin
         if (wr && (reg_addr == IO_LED)) begin
            led_reg <= bus.write_data[7:0];
         end
         // A fresh debounce event outranks the read-to-clear so no event is lost.
         if (changed) begin
            chg_flag <= 1'b1;
         end else if (rd && (reg_addr == IO_SWCHG)) begin
            chg_flag <= 1'b0;
         end
         if (wr && (reg_addr == IO_CYC)) begin
            cyc_cnt <= bus.write_data;
         end else begin
            cyc_cnt <= cyc_cnt + 16'd1;
         end
      end
   end

endmodule

// File: tb/tb_mmio_io_unit.sv
// Directed scoreboard bench for mmio_io_unit with a short debounce window.
module tb_mmio_io_unit;
   import io_pkg::*;

   logic        clk;
   logic        reset;
   logic [7:0]  sw_in;
   logic [7:0]  ledr;
   wire  [15:0] read_data;

   int total;
   int bad;
   logic [15:0] exp_q[$];

   mmio_io_unit_if bus ();

   mmio_io_unit #(
      .DB_CYCLES (4),
      .DB_W      (16)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .bus       (bus),
      .read_data (read_data),
      .sw_in     (sw_in),
      .ledr      (ledr)
   );

   // clock / reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL timeout: total=%0d bad=%0d", total, bad);
      $fatal(1, "timeout");
   end

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got=%h want=%h", name, act, exp);
      end
   endtask

   // driver tasks: each occupies one bus cycle starting just after a rising edge
   task automatic cycle_end();
      @(posedge clk);
      #1;
   endtask

   task automatic rd(input logic [8:0] addr, input logic [15:0] exp);
      bus.mem_cmd  = MREAD;
      bus.mem_addr = addr;
      exp_q.push_back(exp);
      cycle_end();
   endtask

   task automatic wr(input logic [8:0] addr, input logic [15:0] data);
      bus.mem_cmd    = MWRITE;
      bus.mem_addr   = addr;
      bus.write_data = data;
      cycle_end();
   endtask

   task automatic nop(input int n);
      for (int i = 0; i < n; i++) begin
         bus.mem_cmd  = MNONE;
         bus.mem_addr = 9'h000;
         cycle_end();
      end
   endtask

   task automatic undriven(input string name, input logic [1:0] cmd, input logic [8:0] addr);
      bus.mem_cmd  = cmd;
      bus.mem_addr = addr;
      #2;
      check(name, {15'h0, bus.read_en}, 16'h0000);
      cycle_end();
   endtask

   // scoreboard monitor: pops whenever the unit drives the read bus
   always @(negedge clk) begin
      if (bus.read_en === 1'b1) begin
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_drive: got=%h want=none", read_data);
         end else begin
            check("read_data", read_data, exp_q.pop_front());
         end
      end
   end

   initial begin
      total          = 0;
      bad            = 0;
      reset          = 1'b1;
      sw_in          = 8'h00;
      bus.mem_cmd    = MNONE;
      bus.mem_addr   = 9'h000;
      bus.write_data = 16'h0000;
      cycle_end();
      cycle_end();
      check("reset_ledr", {8'h00, ledr}, 16'h0000);
      check("reset_not_driven", {15'h0, bus.read_en}, 16'h0000);
      reset = 1'b0;

      // first cycle after reset: counter still zero
      rd(9'h142, 16'h0000);
      rd(9'h100, 16'h0000);

      // LED write / readback, RAM-side address and idle command leave bus undriven
      wr(9'h100, 16'hABCD);
      check("ledr_after_write", {8'h00, ledr}, 16'h00CD);
      rd(9'h100, 16'h00CD);
      undriven("ram_addr_undriven", MREAD, 9'h0FF);
      undriven("cmd_zero_undriven", 2'd0, 9'h100);
      undriven("cmd_none_undriven", MNONE, 9'h142);

      // debounce: exact latency of DB_CYCLES+2 edges
      sw_in = 8'h5A;
      nop(5);
      rd(9'h140, 16'h0000);
      rd(9'h140, 16'h005A);
      rd(9'h141, 16'h0001);
      rd(9'h141, 16'h0000);

      // short bounce is rejected
      sw_in = 8'h00;
      nop(2);
      sw_in = 8'h5A;
      nop(6);
      rd(9'h140, 16'h005A);
      rd(9'h141, 16'h0000);

      // flag set and read-to-clear on the same edge: set wins
      sw_in = 8'h3C;
      nop(6);
      sw_in = 8'hC3;
      nop(5);
      rd(9'h141, 16'h0001);
      rd(9'h141, 16'h0001);
      rd(9'h141, 16'h0000);
      rd(9'h140, 16'h00C3);

      // cycle counter load and wrap
      wr(9'h142, 16'hFFFE);
      rd(9'h142, 16'hFFFE);
      rd(9'h142, 16'hFFFF);
      rd(9'h142, 16'h0000);
      wr(9'h142, 16'h0010);
      nop(3);
      rd(9'h142, 16'h0013);

      // read-only and unmapped addresses
      wr(9'h140, 16'h00FF);
      rd(9'h140, 16'h00C3);
      rd(9'h1A0, 16'h0000);
      wr(9'h1A0, 16'h1234);
      rd(9'h100, 16'h00CD);
      check("ledr_hold", {8'h00, ledr}, 16'h00CD);

      // reset mid-debounce discards everything
      sw_in = 8'hA5;
      nop(3);
      reset = 1'b1;
      nop(1);
      reset = 1'b0;
      check("ledr_after_reset", {8'h00, ledr}, 16'h0000);
      rd(9'h100, 16'h0000);
      rd(9'h141, 16'h0000);
      rd(9'h142, 16'h0002);
      nop(2);
      rd(9'h140, 16'h0000);
      rd(9'h140, 16'h00A5);
      rd(9'h141, 16'h0001);

      nop(2);
      check("queue_drained", 16'(exp_q.size()), 16'h0000);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
